xin_bitplane_feeder: RTL and testbench

- Upstream input stage of the CIM macro datapath.
- Accepts one vector of INPUT_WIDTH multi-bit activations per handshake and streams it as ACT_BITS bit-planes, MSB first, one plane per cycle on xin.
- Drives the accumulate-control strobes (start_acc, signed_op) in step with each plane, and flags when the downstream accumulator result for a vector is valid.
- Holds one vector in flight plus one pending vector, so vectors stream back-to-back with no bubble.

---
 rtl/xin_bitplane_feeder.sv | 149 ++++++++++++++
 tb/tb_xin_bitplane_feeder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/xin_bitplane_feeder.sv
// xin_bitplane_feeder: takes one vector of multi-bit activations per handshake
// and presents it as bit-planes on xin, MSB first, one plane per cycle. It
// also drives the accumulate strobes and flags when the accumulator result is
// valid. A single pending slot lets consecutive vectors stream with no bubble.
module xin_bitplane_feeder #(
  parameter int INPUT_WIDTH = 144,
  parameter int ACT_BITS    = 8,
  parameter int ACC_LAT     = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [INPUT_WIDTH*ACT_BITS-1:0] in_data,
  input  logic                            in_signed,
  output logic [INPUT_WIDTH-1:0]          xin,
  output logic                            plane_valid,
  output logic                            start_acc,
  output logic                            signed_op,
  output logic                            busy,
  output logic                            nout_valid
);

  localparam int DW = INPUT_WIDTH * ACT_BITS;
  localparam int KW = $clog2(ACT_BITS);
  localparam logic [KW-1:0] K_MSB = KW'(ACT_BITS - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                 state_q;
  logic [KW-1:0]          k_q;
  logic                   pend_v_q;
  logic                   pend_sgn_q;
  logic [DW-1:0]          vec_q;
  logic [DW-1:0]          pend_q;
  logic [ACC_LAT-1:0]     dl_q;
  logic [INPUT_WIDTH-1:0] xin_q;
  logic                   pv_q;
  logic                   sa_q;
  logic                   so_q;

  logic          xfer;
  logic          last_plane;
  logic          load_in;
  logic          load_pend;
  logic          fill_pend;
  logic [DW-1:0] new_vec;
  logic          new_sgn;

  // Extract bit kk of every element as one plane.
  function automatic logic [INPUT_WIDTH-1:0] plane_of(input logic [DW-1:0] v,
                                                      input logic [KW-1:0] kk);
    logic [INPUT_WIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < INPUT_WIDTH; i++) begin
      p[i] = v[i*ACT_BITS + int'(kk)];
    end
    return p;
  endfunction

  // Ready depends only on the registered slot; held low while in reset.
  assign in_ready   = rst_n && !pend_v_q;
  assign xfer       = in_valid && in_ready;
  assign last_plane = (state_q == S_STREAM) && (k_q == '0);
  // An incoming vector goes straight to the shift register when idle, or when
  // it arrives on the final plane with nothing pending (bypass, no bubble).
  assign load_in    = xfer && ((state_q == S_IDLE) || (last_plane && !pend_v_q));
  assign load_pend  = last_plane && pend_v_q;
  assign fill_pend  = xfer && !load_in;
  assign new_vec    = load_in ? in_data : pend_q;
  assign new_sgn    = load_in ? in_signed : pend_sgn_q;

  assign xin         = xin_q;
  assign plane_valid = pv_q;
  assign start_acc   = sa_q;
  assign signed_op   = so_q;
  assign nout_valid  = dl_q[ACC_LAT-1];
  assign busy        = pv_q || pend_v_q || (|dl_q);

  // Vector storage: active shift source and the pending slot.
  always_ff @(posedge clk) begin
    if (load_in || load_pend) begin
      vec_q <= new_vec;
    end
    if (fill_pend) begin
      pend_q     <= in_data;
      pend_sgn_q <= in_signed;
    end
  end

  // Plane sequencer, registered outputs, pending flag and result delay line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      pend_v_q <= 1'b0;
      dl_q     <= '0;
      xin_q    <= '0;
      pv_q     <= 1'b0;
      sa_q     <= 1'b0;
      so_q     <= 1'b0;
    end else begin
      dl_q <= ACC_LAT'({dl_q, last_plane});
      if (fill_pend) begin
        pend_v_q <= 1'b1;
      end else if (load_pend) begin
        pend_v_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (load_in) begin
            state_q <= S_STREAM;
            k_q     <= K_MSB;
            pv_q    <= 1'b1;
            xin_q   <= plane_of(in_data, K_MSB);
            sa_q    <= 1'b1;
            so_q    <= in_signed;
          end else begin
            pv_q  <= 1'b0;
            xin_q <= '0;
            sa_q  <= 1'b0;
            so_q  <= 1'b0;
          end
        end
        S_STREAM: begin
          if (k_q != '0) begin
            k_q   <= k_q - 1'b1;
            xin_q <= plane_of(vec_q, k_q - 1'b1);
            sa_q  <= 1'b0;
            so_q  <= 1'b0;
          end else if (load_in || load_pend) begin
            k_q   <= K_MSB;
            xin_q <= plane_of(new_vec, K_MSB);
            sa_q  <= 1'b1;
            so_q  <= new_sgn;
          end else begin
            state_q <= S_IDLE;
            pv_q    <= 1'b0;
            xin_q   <= '0;
            sa_q    <= 1'b0;
            so_q    <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xin_bitplane_feeder.sv
// Testbench for xin_bitplane_feeder: two instances (ACC_LAT 1 and 4) share
// one stimulus stream and are compared each cycle against a timeline model
// that schedules every accepted vector to its plane window.
module tb_xin_bitplane_feeder;

  localparam int IW   = 144;
  localparam int AB   = 8;
  localparam int DW   = IW * AB;
  localparam int NMAX = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_signed;

  logic          rdy1, pv1, sa1, so1, busy1, nv1;
  logic [IW-1:0] xin1;
  logic          rdy4, pv4, sa4, so4, busy4, nv4;
  logic [IW-1:0] xin4;

  always #5 clk = ~clk;

  xin_bitplane_feeder #(.INPUT_WIDTH(IW), .ACT_BITS(AB), .ACC_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .in_signed(in_signed), .xin(xin1), .plane_valid(pv1),
    .start_acc(sa1), .signed_op(so1), .busy(busy1), .nout_valid(nv1));

  xin_bitplane_feeder #(.INPUT_WIDTH(IW), .ACT_BITS(AB), .ACC_LAT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4),
    .in_data(in_data), .in_signed(in_signed), .xin(xin4), .plane_valid(pv4),
    .start_acc(sa4), .signed_op(so4), .busy(busy4), .nout_valid(nv4));

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  bit chk_on = 1'b0;

  // Model: accepted vectors with acceptance cycle and first-plane cycle.
  logic [DW-1:0] vdata [NMAX];
  bit            vsgn  [NMAX];
  int            vacc  [NMAX];
  int            vstart[NMAX];
  int            nv         = 0;
  int            base       = 0;
  int            last_start = -1000;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    ntests++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] r;
    for (int w = 0; w < DW; w += 32) r[w +: 32] = $urandom;
    return r;
  endfunction

  // One clock cycle: apply inputs, check this cycle's outputs, update model.
  task automatic step(input bit rv, input bit v, input logic [DW-1:0] d, input bit s);
    logic [IW-1:0] e_xin;
    bit e_pv, e_sa, e_so, e_pend, e_n1, e_n4, e_b1, e_b4, e_rdy;
    int lo;
    rst_n = rv; in_valid = v; in_data = d; in_signed = s;
    #1;
    e_xin = '0; e_pv = 0; e_sa = 0; e_so = 0; e_pend = 0;
    e_n1 = 0; e_n4 = 0; e_b1 = 0; e_b4 = 0;
    lo = (nv - 8 > base) ? nv - 8 : base;
    for (int j = lo; j < nv; j++) begin
      int st, lp;
      st = vstart[j];
      lp = st + AB - 1;
      if (cyc >= st && cyc <= lp) begin
        e_pv = 1;
        for (int i = 0; i < IW; i++) e_xin[i] = vdata[j][i*AB + (lp - cyc)];
        if (cyc == st) begin e_sa = 1; e_so = vsgn[j]; end
      end
      if (vacc[j] < cyc && cyc < st) e_pend = 1;
      if (cyc == lp + 1) e_n1 = 1;
      if (cyc == lp + 4) e_n4 = 1;
      if (cyc > lp && cyc <= lp + 1) e_b1 = 1;
      if (cyc > lp && cyc <= lp + 4) e_b4 = 1;
    end
    e_rdy = rv && !e_pend;
    if (chk_on) begin
      chk("ready1", 256'(rdy1), 256'(e_rdy));
      chk("ready4", 256'(rdy4), 256'(e_rdy));
      chk("xin1", 256'(xin1), 256'(e_xin));
      chk("xin4", 256'(xin4), 256'(e_xin));
      chk("plane_valid1", 256'(pv1), 256'(e_pv));
      chk("plane_valid4", 256'(pv4), 256'(e_pv));
      chk("start_acc1", 256'(sa1), 256'(e_sa));
      chk("start_acc4", 256'(sa4), 256'(e_sa));
      chk("signed_op1", 256'(so1), 256'(e_so));
      chk("signed_op4", 256'(so4), 256'(e_so));
      chk("nout_valid1", 256'(nv1), 256'(e_n1));
      chk("nout_valid4", 256'(nv4), 256'(e_n4));
      chk("busy1", 256'(busy1), 256'(e_pv || e_pend || e_b1));
      chk("busy4", 256'(busy4), 256'(e_pv || e_pend || e_b4));
    end
    if (v && e_rdy && nv < NMAX) begin
      vdata[nv]  = d;
      vsgn[nv]   = s;
      vacc[nv]   = cyc;
      vstart[nv] = (cyc + 1 > last_start + AB) ? cyc + 1 : last_start + AB;
      last_start = vstart[nv];
      nv++;
    end
    if (!rv) begin
      base       = nv;
      last_start = -1000;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk_on = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] da;
    int p;
    da = '0;
    da[0 +: AB]        = 8'hA5;
    da[(IW-1)*AB +: AB] = 8'h80;

    // Reset held with in_valid high.
    for (int i = 0; i < 3; i++) step(0, 1, rand_vec(), 1);

    // Single unsigned vector, then the same vector signed.
    step(1, 1, da, 0);
    for (int i = 0; i < 12; i++) step(1, 0, '0, 0);
    step(1, 1, da, 1);
    for (int i = 0; i < 12; i++) step(1, 0, '0, 0);

    // Back-to-back with backpressure.
    for (int i = 0; i < 26; i++) step(1, 1, rand_vec(), 1'($urandom));
    for (int i = 0; i < 20; i++) step(1, 0, '0, 0);

    // Reset mid-stream with a pending vector.
    step(1, 1, rand_vec(), 0);
    step(1, 1, rand_vec(), 1);
    for (int i = 0; i < 3; i++) step(1, 1, rand_vec(), 0);
    step(0, 0, '0, 0);
    for (int i = 0; i < 15; i++) step(1, 0, '0, 0);

    // Randomized traffic with varying load and occasional resets.
    for (int i = 0; i < 2400; i++) begin
      p = (i / 400) % 3;
      step(($urandom_range(0, 199) != 0),
           (p == 0) ? 1'b1 : (p == 1) ? 1'($urandom) : ($urandom_range(0, 6) == 0),
           rand_vec(), 1'($urandom));
    end
    for (int i = 0; i < 20; i++) step(1, 0, '0, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
